// File: rtl/sched_delay_line.sv
// -----------------------------------------------------------------------------
// sched_delay_line
//
// Purpose:
//   Accepts a one-shot transaction (start) carrying a delay (dly). After the
//   delay has elapsed, the OR of a and b is written to the registered output y,
//   and done pulses for one cycle. By default the OR is captured when the
//   transaction is accepted (sample-then-wait). With the optional mode feature,
//   mode=1 instead samples a|b on the update edge (wait-then-sample).
//
// Configuration macro:
//   SCHED_REGULAR_EN - adds the mode port and the captured-mode register.
//                      When it is undefined, the block behaves as if mode=0.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   transaction request; only looked at while busy=0
//   dly    in   [DELAY_W] delay in cycles, captured with start
//   a, b   in   OR operands
//   mode   in   (SCHED_REGULAR_EN only) 0 = sample-then-wait, 1 = wait-then-sample
//   y      out  registered result; holds between transactions
//   busy   out  high while a transaction is pending
//   done   out  one-cycle pulse in the cycle after y was updated
// -----------------------------------------------------------------------------
module sched_delay_line #(
  parameter int DELAY_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DELAY_W-1:0] dly,
  input  logic               a,
  input  logic               b,
`ifdef SCHED_REGULAR_EN
  input  logic               mode,
`endif
  output logic               y,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [DELAY_W-1:0] CNT_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] CNT_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [DELAY_W-1:0] cnt_r;
  logic [DELAY_W-1:0] cnt_nxt_s;
  logic               s_r;
  logic               s_nxt_s;
  logic               y_r;
  logic               y_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               accept_s;
  logic               mode_cap_s;

  assign accept_s = (state_r == ST_IDLE) && start;

`ifdef SCHED_REGULAR_EN
  logic mode_r;

  // Captured mode register: latched only at acceptance, ignored changes in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= mode;
    end else begin
      mode_r <= mode_r;
    end
  end

  assign mode_cap_s = mode_r;
`else
  assign mode_cap_s = 1'b0;
`endif

  // Next-state, counter, capture and result logic for the two-state FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    s_nxt_s     = s_r;
    y_nxt_s     = y_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          s_nxt_s = a | b;
          if (dly == CNT_ZERO) begin
            // Zero delay completes at the acceptance edge; both modes sample now.
            y_nxt_s     = a | b;
            done_nxt_s  = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s   = dly;
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A count of 1 here means this edge brings the counter to 0. A count of
        // 0 cannot occur in WAIT; it is folded into completion so the counter
        // can never wrap.
        if (cnt_r <= CNT_ONE) begin
          y_nxt_s     = mode_cap_s ? (a | b) : s_r;
          done_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      s_r     <= 1'b0;
      y_r     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      s_r     <= s_nxt_s;
      y_r     <= y_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign y    = y_r;
  assign busy = (state_r == ST_WAIT);
  assign done = done_r;

endmodule
